// File: rtl/argmax_sequencer.sv
// Streaming argmax: collects NUM_INPUTS signed scores per frame and reports the
// index and value of the largest one. Ties keep the earliest index.
module argmax_sequencer #(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned NUM_INPUTS  = 10,
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          in_valid,
    input  logic signed [BIT_WIDTH-1:0]   in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic        [INDEX_WIDTH-1:0] out_idx,
    output logic signed [BIT_WIDTH-1:0]   out_val,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int unsigned CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic        [CNT_W-1:0]       r_cnt;
    logic        [CNT_W-1:0]       w_cnt_nxt;
    logic signed [BIT_WIDTH-1:0]   r_max;
    logic signed [BIT_WIDTH-1:0]   w_max_nxt;
    logic        [INDEX_WIDTH-1:0] r_idx;
    logic        [INDEX_WIDTH-1:0] w_idx_nxt;
    logic                          r_in_ready;
    logic                          r_out_valid;
    logic                          r_busy;
    logic                          w_in_ready_nxt;
    logic                          w_out_valid_nxt;
    logic                          w_busy_nxt;
    logic                          w_accept;
    logic                          w_take;

    // r_in_ready mirrors "state == COLLECT", so acceptance never depends on in_valid timing
    assign w_accept = r_in_ready & in_valid;
    assign w_take   = (r_cnt == '0) || (in_data > r_max);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_max       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_max       <= w_max_nxt;
            r_idx       <= w_idx_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state, running-max update and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_max_nxt   = r_max;
        w_idx_nxt   = r_idx;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = COLLECT;
                    w_cnt_nxt   = '0;
                end
            end
            COLLECT: begin
                // abort wins over a coincident beat, which is dropped
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_accept) begin
                    if (w_take) begin
                        w_max_nxt = in_data;
                        w_idx_nxt = INDEX_WIDTH'(r_cnt);
                    end
                    if (r_cnt == LAST_BEAT) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_state_nxt == COLLECT);
        w_out_valid_nxt = (w_state_nxt == DONE);
        w_busy_nxt      = (w_state_nxt != IDLE);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_idx   = r_idx;
    assign out_val   = r_max;

endmodule

// File: tb/tb_argmax_sequencer.sv
// Self-checking bench: directed frames plus random traffic, compared every cycle
// against a frame-level argmax model.
module tb_argmax_sequencer;

    localparam int unsigned BW = 8;
    localparam int unsigned N  = 10;
    localparam int unsigned IW = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic signed [BW-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic        [IW-1:0] out_idx;
    logic signed [BW-1:0] out_val;
    logic                 out_ready;
    logic                 busy;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: 0 idle, 1 collecting, 2 result pending
    int m_mode = 0;
    int m_q[$];
    int m_res_idx = 0;
    int m_res_val = 0;
    bit m_ret_known = 1'b1;

    int f1 [N] = '{3, -5, 7, 2, 7, 0, -1, 6, 1, 4};
    int f2 [N] = '{-8, -3, -128, -3, -9, -20, -7, -4, -100, -50};
    int f3 [N] = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 127};
    int f4 [N] = '{0, -3, 5, 8, 2, -1, 4, 8, 3, 9};

    argmax_sequencer #(.BIT_WIDTH(BW), .NUM_INPUTS(N), .INDEX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_val   (out_val),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // frame-level behaviour: argmax of the accepted scores, earliest index on ties
    task automatic model_update();
        int best_i;
        int best_v;
        if (rst) begin
            m_mode = 0;
            m_q.delete();
            m_res_idx = 0;
            m_res_val = 0;
            m_ret_known = 1'b1;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_q.delete();
            end
        end else if (m_mode == 1) begin
            if (abort) begin
                m_mode = 0;
            end else if (in_valid) begin
                if (m_q.size() == 0) m_ret_known = 1'b0;
                m_q.push_back(int'(in_data));
                if (m_q.size() == N) begin
                    best_i = 0;
                    best_v = m_q[0];
                    for (int i = 1; i < N; i++) begin
                        if (m_q[i] > best_v) begin
                            best_v = m_q[i];
                            best_i = i;
                        end
                    end
                    m_res_idx = best_i;
                    m_res_val = best_v;
                    m_ret_known = 1'b1;
                    m_mode = 2;
                end
            end
        end else begin
            if (out_ready) m_mode = 0;
        end
    endtask

    task automatic compare();
        chk("in_ready", int'(in_ready), int'(m_mode == 1));
        chk("busy", int'(busy), int'(m_mode != 0));
        chk("out_valid", int'(out_valid), int'(m_mode == 2));
        if (m_mode == 2 || (m_mode == 0 && m_ret_known)) begin
            chk("out_idx", int'(out_idx), m_res_idx);
            chk("out_val", int'(out_val), m_res_val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic run_frame(input int v [N], input bit gaps);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    in_data  = BW'($urandom);
                    step();
                end
            end
            in_valid = 1'b1;
            in_data  = BW'(v[i]);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_val", int'(out_val), 0);
        rst = 1'b0;
        step();

        // back-to-back frame, tie keeps index 2
        out_ready = 1'b1;
        run_frame(f1, 1'b0);
        chk("f1_valid", int'(out_valid), 1);
        chk("f1_idx", int'(out_idx), 2);
        chk("f1_val", int'(out_val), 7);
        step();
        chk("f1_released", int'(out_valid), 0);
        chk("f1_retain_val", int'(out_val), 7);
        out_ready = 1'b0;

        // all negative with random gaps
        run_frame(f2, 1'b1);
        chk("f2_idx", int'(out_idx), 1);
        chk("f2_val", int'(out_val), -3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // all equal at max positive; held result with ignored start/abort
        run_frame(f3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            start = c[0];
            abort = ~c[0];
            step();
            chk("f3_hold_valid", int'(out_valid), 1);
            chk("f3_hold_idx", int'(out_idx), 0);
            chk("f3_hold_val", int'(out_val), 127);
        end
        abort = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        chk("f3_start_ignored_busy", int'(busy), 0);

        // abort coincident with 5th beat
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = BW'(50 + i);
            step();
        end
        abort = 1'b1;
        in_data = BW'(100);
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle_busy", int'(busy), 0);
        repeat (3) begin
            step();
            chk("abort_no_valid", int'(out_valid), 0);
        end
        out_ready = 1'b1;
        run_frame(f4, 1'b0);
        chk("f4_idx", int'(out_idx), 9);
        chk("f4_val", int'(out_val), 9);
        step();
        out_ready = 1'b0;

        // reset mid-frame, then beats without start are ignored
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = BW'(20 + i);
            step();
        end
        rst = 1'b1;
        abort = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        chk("rst_mid_idx", int'(out_idx), 0);
        chk("rst_mid_val", int'(out_val), 0);
        chk("rst_mid_busy", int'(busy), 0);
        repeat (5) begin
            in_valid = 1'b1;
            in_data  = BW'($urandom);
            step();
            chk("no_start_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = BW'($urandom);
            out_ready = ($urandom_range(0, 9) < 4);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/argmax_sequencer.md
ARGMAX_SEQUENCER -- requirements
Module: argmax_sequencer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, width of each signed class score.
REQ-002 SHALL have parameter NUM_INPUTS, default 10, number of scores per classification frame.
REQ-003 SHALL have parameter INDEX_WIDTH, default 4, width of class index; 2**INDEX_WIDTH >= NUM_INPUTS.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-008 abort  input  1  cancel the current frame; honoured only in COLLECT.
REQ-009 in_valid  input  1  in_data carries a score this cycle.
REQ-010 in_data  input  BIT_WIDTH  signed two's-complement score.
REQ-011 in_ready  output  1  block accepts a score this cycle.
REQ-012 out_valid  output  1  result available.
REQ-013 out_idx  output  INDEX_WIDTH  index (0-based arrival order) of the maximum score.
REQ-014 out_val  output  BIT_WIDTH  signed maximum score.
REQ-015 out_ready  input  1  consumer takes the result.
REQ-016 busy  output  1  high in COLLECT or DONE.

Function
REQ-017 SHALL implement states IDLE, COLLECT, DONE.
REQ-018 IDLE: start=1 -> COLLECT next cycle, beat counter cleared to 0; otherwise stay.
REQ-019 in_ready SHALL be 1 only in COLLECT; it is a registered-state decode, not dependent on in_valid.
REQ-020 Beat accepted when in_valid && in_ready; beats with in_valid=1 outside COLLECT SHALL be ignored.
REQ-021 First accepted beat (counter 0) SHALL unconditionally load running max = in_data, running idx = 0.
REQ-022 Subsequent beat k SHALL replace running max/idx with in_data/k only if in_data > running max (signed, strict).
REQ-023 Ties SHALL keep the earlier (lower) index.
REQ-024 Counter SHALL increment per accepted beat; on acceptance of beat NUM_INPUTS-1 -> DONE next cycle.
REQ-025 out_valid SHALL assert the cycle after the last beat is accepted (latency 1) and hold, with out_idx/out_val stable, until out_ready=1.
REQ-026 DONE with out_ready=1 -> IDLE next cycle, out_valid deasserts next cycle.
REQ-027 start asserted in COLLECT or DONE SHALL be ignored, including start coincident with the out_ready handshake.
REQ-028 abort=1 in COLLECT -> IDLE next cycle, no out_valid; a beat accepted in the same cycle SHALL be discarded.
REQ-029 abort outside COLLECT SHALL be ignored.
REQ-030 Gaps (in_valid=0) in COLLECT SHALL stall without changing counter or running max.
REQ-031 out_idx/out_val SHALL retain the last result in IDLE until the next frame's first beat overwrites them.
REQ-032 Counter SHALL be wide enough for NUM_INPUTS-1 and never wrap within a frame.

Reset
REQ-033 rst=1 SHALL force IDLE, counter=0, out_valid=0, in_ready=0, busy=0, out_idx=0, out_val=0 at the next clk edge.
REQ-034 rst SHALL take priority over start, abort, beats and out_ready, including mid-frame and in DONE.

Verification
REQ-035 start, scores 3,-5,7,2,7,0,-1,6,1,4 back-to-back, out_ready=1 -> out_valid 1 cycle after 10th beat, out_idx=2, out_val=7 (tie at 4 keeps 2).
REQ-036 start, scores -8,-3,-128,-3,-9,-20,-7,-4,-100,-50 with random in_valid gaps -> out_idx=1, out_val=-3; counter frozen during gaps.
REQ-037 all ten scores 127 -> out_idx=0, out_val=127; out_ready held 0 for 5 cycles -> out_valid and outputs stable, start pulses ignored.
REQ-038 abort after 4th beat (abort and 5th beat same cycle) -> IDLE, no out_valid; new start + 10 scores with max 9 at index 9 -> out_idx=9, out_val=9.
REQ-039 rst asserted after 6th beat -> next cycle all outputs 0, state IDLE; in_valid beats without start ignored, in_ready stays 0.
